muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, next to the ALU; driven by the same in1/in2 operand buses and the same Sign convention.
- Owns the architectural HI/LO registers, which feed the EX result mux for MFHI/MFLO.
- Exposes busy/done so the hazard unit can stall dependent instructions.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_core.sv | 56 +++++
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the divide-by-zero quotient pattern.
package muldiv_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage operand/control bundle into the multiply/divide unit and its
// HI/LO + busy/done view back to the pipeline.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic             Sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             mthi;
  logic             mtlo;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, Sign, in1, in2, mthi, mtlo, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, Sign, in1, in2, mthi, mtlo, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_core.sv
// Combinational iteration datapath: one radix-2 shift-add or restoring
// shift-subtract step on a 2W+1 accumulator, plus the final sign correction.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               op_div_i,
  input  logic [2*WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               neg_q_i,
  input  logic               neg_r_i,
  output logic [2*WIDTH:0]   acc_step_o,
  output logic [WIDTH-1:0]   hi_fix_o,
  output logic [WIDTH-1:0]   lo_fix_o
);

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_up;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  // Multiply: upper half (with carry bit) accumulates the multiplicand, then shift right
  assign mul_sum = acc_i[2*WIDTH:WIDTH] + {1'b0, b_i};

  // Divide: shifted partial remainder; borrow out of the W+2 subtract means "restore"
  assign div_up    = acc_i[2*WIDTH-1:WIDTH-1];
  assign div_trial = {1'b0, div_up} - {2'b00, b_i};

  always_comb begin
    acc_step_o = acc_i;
    if (op_div_i) begin
      if (!div_trial[WIDTH+1])
        acc_step_o = {div_trial[WIDTH:0], acc_i[WIDTH-2:0], 1'b1};
      else
        acc_step_o = {acc_i[2*WIDTH-1:0], 1'b0};
    end else begin
      if (acc_i[0])
        acc_step_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
      else
        acc_step_o = {1'b0, acc_i[2*WIDTH:1]};
    end
  end

  assign prod     = acc_i[2*WIDTH-1:0];
  assign prod_fix = neg_q_i ? -prod : prod;

  always_comb begin
    hi_fix_o = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix_o = prod_fix[WIDTH-1:0];
    if (op_div_i) begin
      lo_fix_o = neg_q_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
      hi_fix_o = neg_r_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO; result WIDTH+2 cycles after start (2 for div-by-zero),
// busy stalls the pipeline and start is ignored until idle. MULDIV_FAST_MUL_EN: single-step multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_div_q, op_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div0;
  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  logic [2*WIDTH-1:0] fast_prod;

  assign mag_a = (bus.Sign && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
  assign mag_b = (bus.Sign && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
  assign div0  = (bus.op == OP_DIV) && (bus.in2 == '0);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
  localparam bit FAST_MUL = 1'b0;
  assign fast_prod = '0;
`endif

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .op_div_i   (op_div_q),
    .acc_i      (acc_q),
    .b_i        (b_q),
    .neg_q_i    (neg_q_q),
    .neg_r_i    (neg_r_q),
    .acc_step_o (acc_step),
    .hi_fix_o   (hi_fix),
    .lo_fix_o   (lo_fix)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_div_d = op_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mthi) hi_d = bus.in1;
        if (bus.mtlo) lo_d = bus.in1;
        if (bus.start && !bus.flush) begin
          op_div_d = (bus.op == OP_DIV);
          b_d      = mag_b;
          neg_q_d  = bus.Sign & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
          neg_r_d  = bus.Sign & bus.in1[WIDTH-1];
          cnt_d    = CNT_W'(WIDTH - 1);
          acc_d    = {{(WIDTH+1){1'b0}}, mag_a};
          state_d  = CALC;
          // Div-by-zero preloads the final {HI,LO} and bypasses the iterations
          if (div0) begin
            acc_d   = {1'b0, bus.in1, DIV0_LO[WIDTH-1:0]};
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = FIX;
          end else if (FAST_MUL && (bus.op == OP_MUL)) begin
            acc_d   = {1'b0, fast_prod};
            state_d = FIX;
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          hi_d   = hi_fix;
          lo_d   = lo_fix;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_div_q <= op_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result table plus hand-written
// sequences for moves, flush, reset and start arbitration.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int DIV_LAT = W + 2;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          op;
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    int            lat;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives start for cycle T (caller sits just after an edge); returns in T+1
  // with op/Sign/operands scrambled to prove they were latched.
  task automatic launch(input logic o, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.Sign  = s;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.Sign  = ~s;
    bus.in1   = 32'hDEAD_0001;
    bus.in2   = 32'h0000_0000;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output logic busy_at_done);
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    busy_at_done = bus.busy;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) n++;
    end
  endtask

  task automatic move_both(input logic [W-1:0] v);
    @(posedge clk); #1;
    bus.in1  = v;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
  endtask

  initial begin
    int   lat, bcnt, nd;
    logic bd;

    tbl[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT};
    tbl[1]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    tbl[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, DIV_LAT};
    tbl[3]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 2};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 2};
    tbl[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, MUL_LAT};
    tbl[6]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT};
    tbl[7]  = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT};
    tbl[8]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT};
    tbl[10] = '{1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, DIV_LAT};
    tbl[11] = '{1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, MUL_LAT};
    tbl[12] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, DIV_LAT};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0009, 32'h0000_0005, 32'h0000_0000, DIV_LAT};

    bus.start = 1'b0; bus.op = 1'b0; bus.Sign = 1'b0;
    bus.in1 = '0; bus.in2 = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.flush = 1'b0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_hi",   bus.hi,   0);
    chk("reset_lo",   bus.lo,   0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      launch(tbl[i].op, tbl[i].sgn, tbl[i].a, tbl[i].b);
      wait_done(lat, bcnt, bd);
      chk($sformatf("v%0d_hi", i),        bus.hi, tbl[i].hi);
      chk($sformatf("v%0d_lo", i),        bus.lo, tbl[i].lo);
      chk($sformatf("v%0d_latency", i),   lat,    tbl[i].lat);
      chk($sformatf("v%0d_busy_cyc", i),  bcnt,   tbl[i].lat - 1);
      chk($sformatf("v%0d_busy_done", i), bd,     0);
    end

    // mthi + mtlo together in IDLE
    move_both(32'h0000_BEEF);
    chk("mvboth_hi", bus.hi, 32'h0000_BEEF);
    chk("mvboth_lo", bus.lo, 32'h0000_BEEF);

    // mthi at T+5 is ignored while busy
    @(posedge clk); #1;
    launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (4) @(posedge clk);
    #1;
    bus.in1  = 32'hAAAA_0000;
    bus.mthi = 1'b1;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    chk("busy_mthi_hi_mid", bus.hi, 32'h0000_BEEF);
    wait_done(lat, bcnt, bd);
    chk("busy_mthi_hi", bus.hi, 32'hFFFF_FFFF);
    chk("busy_mthi_lo", bus.lo, 32'hFFFF_FFFD);

    // flush at T+10
    move_both(32'h0000_BEEF);
    @(posedge clk); #1;
    launch(1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    count_dones(40, nd);
    chk("flush_dones", nd, 0);
    chk("flush_hi", bus.hi, 32'h0000_BEEF);
    chk("flush_lo", bus.lo, 32'h0000_BEEF);

    // asynchronous reset at T+12
    @(posedge clk); #1;
    launch(1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_hi",   bus.hi,   0);
    chk("rst_mid_lo",   bus.lo,   0);
    chk("rst_mid_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    count_dones(40, nd);
    chk("rst_mid_dones", nd, 0);

    // flush together with start in IDLE
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1;
    bus.op = 1'b1; bus.Sign = 1'b0;
    bus.in1 = 32'h0000_0064; bus.in2 = 32'h0000_0007;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", bus.busy, 0);
    count_dones(40, nd);
    chk("flush_start_dones", nd, 0);

    // start while busy is dropped
    @(posedge clk); #1;
    launch(1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.Sign = 1'b0;
    bus.in1 = 32'hFFFF_FFFF; bus.in2 = 32'h0000_0002;
    @(posedge clk); #1;
    bus.start = 1'b0;
    count_dones(60, nd);
    chk("dup_start_dones", nd, 1);
    chk("dup_start_hi", bus.hi, 32'h0000_0002);
    chk("dup_start_lo", bus.lo, 32'h0000_000E);

    // mthi in the start cycle, then back-to-back start in the done cycle
    move_both(32'h0000_BEEF);
    @(posedge clk); #1;
    bus.mthi = 1'b1;
    launch(1'b1, 1'b0, 32'h0000_0064, 32'h0000_0007);
    bus.mthi = 1'b0;
    chk("start_mthi_hi_early", bus.hi, 32'h0000_0064);
    chk("start_mthi_lo_early", bus.lo, 32'h0000_BEEF);
    wait_done(lat, bcnt, bd);
    chk("start_mthi_hi", bus.hi, 32'h0000_0002);
    chk("start_mthi_lo", bus.lo, 32'h0000_000E);
    launch(1'b0, 1'b0, 32'h0000_0003, 32'h0000_0005);
    chk("b2b_busy", bus.busy, 1);
    wait_done(lat, bcnt, bd);
    chk("b2b_latency", lat, MUL_LAT);
    chk("b2b_hi", bus.hi, 32'h0000_0000);
    chk("b2b_lo", bus.lo, 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
